// File: rtl/mem_emulator_dp.sv
// rtl/mem_emulator_dp.sv - dual-port buffer memory model: masked writes, pipelined reads, self-zeroing init
// Optional feature macro: MEM_PARITY_EN (per-lane even parity storage, inject and check)
module mem_emulator_dp #(
    parameter int LANES    = 4,
    parameter int LANE_W   = 8,
    parameter int SIZE     = 256,
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = $clog2(SIZE)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    busy_o,
    input  logic                    cenb_a_i,
    input  logic                    wenb_a_i,
    input  logic [ADDR_W-1:0]       addr_a_i,
    input  logic [LANES-1:0]        wmask_a_i,
    input  logic [LANES*LANE_W-1:0] d_a_i,
    output logic [LANES*LANE_W-1:0] q_a_o,
    output logic                    qv_a_o,
    input  logic                    cenb_b_i,
    input  logic [ADDR_W-1:0]       addr_b_i,
    output logic [LANES*LANE_W-1:0] q_b_o,
    output logic                    qv_b_o,
    output logic                    addr_err_o,
    input  logic                    perr_inj_i,
    output logic                    perr_o
);
    localparam int DW = LANES * LANE_W;
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(SIZE - 1);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("mem_emulator_dp: READ_LAT must be in 1..4");
    end

    logic [0:0]          state;
    logic [ADDR_W-1:0]   init_cnt;
    logic                init_wr;
    logic                accept;
    logic                acc_a;
    logic                acc_b;
    logic                in_rng_a;
    logic                in_rng_b;
    logic                wr_a;
    logic [1:0]          rd_req;
    logic [DW-1:0]       rd_samp [2];
    logic [DW-1:0]       mem [SIZE];
    logic [DW-1:0]       pipe_d [2][READ_LAT];
    logic [READ_LAT-1:0] pipe_v [2];

    assign busy_o  = (state == ST_INIT);
    assign init_wr = busy_o && !rst_i;
    assign accept  = !busy_o && !rst_i;
    assign acc_a   = accept && !cenb_a_i;
    assign acc_b   = accept && !cenb_b_i;

    // A power-of-two SIZE leaves no unused address codes to flag.
    if (SIZE == (1 << ADDR_W)) begin : g_full_range
        assign in_rng_a = 1'b1;
        assign in_rng_b = 1'b1;
    end else begin : g_part_range
        assign in_rng_a = (addr_a_i <= LAST_WORD);
        assign in_rng_b = (addr_b_i <= LAST_WORD);
    end

    assign rd_req[0]  = acc_a && wenb_a_i;
    assign rd_req[1]  = acc_b;
    assign wr_a       = acc_a && !wenb_a_i && in_rng_a;
    assign rd_samp[0] = in_rng_a ? mem[addr_a_i] : '0;
    assign rd_samp[1] = in_rng_b ? mem[addr_b_i] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (init_cnt == LAST_WORD) begin
                state <= ST_READY;
            end else begin
                init_cnt <= init_cnt + ADDR_W'(1);
            end
        end
    end

    // Reads sample mem before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk_i) begin
        if (init_wr) begin
            mem[init_cnt] <= '0;
        end else if (wr_a) begin
            for (int k = 0; k < LANES; k++) begin
                if (wmask_a_i[k]) begin
                    mem[addr_a_i][k*LANE_W +: LANE_W] <= d_a_i[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_err_o <= 1'b0;
        end else if ((acc_a && !in_rng_a) || (acc_b && !in_rng_b)) begin
            addr_err_o <= 1'b1;
        end
    end

    // Data stages only load behind a valid, so the last stage holds the last result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < 2; p++) begin
                pipe_v[p] <= '0;
                for (int i = 0; i < READ_LAT; i++) begin
                    pipe_d[p][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pipe_v[p][0] <= rd_req[p];
                if (rd_req[p]) begin
                    pipe_d[p][0] <= rd_samp[p];
                end
                for (int i = 1; i < READ_LAT; i++) begin
                    pipe_v[p][i] <= pipe_v[p][i-1];
                    if (pipe_v[p][i-1]) begin
                        pipe_d[p][i] <= pipe_d[p][i-1];
                    end
                end
            end
        end
    end

    assign q_a_o  = pipe_d[0][READ_LAT-1];
    assign qv_a_o = pipe_v[0][READ_LAT-1];
    assign q_b_o  = pipe_d[1][READ_LAT-1];
    assign qv_b_o = pipe_v[1][READ_LAT-1];

`ifdef MEM_PARITY_EN
    function automatic logic [LANES-1:0] lane_par(input logic [DW-1:0] w);
        logic [LANES-1:0] p;
        p = '0;
        for (int k = 0; k < LANES; k++) begin
            p[k] = ^w[k*LANE_W +: LANE_W];
        end
        return p;
    endfunction

    logic [LANES-1:0] par_mem [SIZE];
    logic [LANES-1:0] par_samp [2];
    logic [LANES-1:0] pipe_p [2][READ_LAT];
    logic [LANES-1:0] wr_par;

    assign wr_par      = lane_par(d_a_i) ^ {LANES{perr_inj_i}};
    assign par_samp[0] = in_rng_a ? par_mem[addr_a_i] : '0;
    assign par_samp[1] = in_rng_b ? par_mem[addr_b_i] : '0;

    always_ff @(posedge clk_i) begin
        if (init_wr) begin
            par_mem[init_cnt] <= '0;
        end else if (wr_a) begin
            for (int k = 0; k < LANES; k++) begin
                if (wmask_a_i[k]) begin
                    par_mem[addr_a_i][k] <= wr_par[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < READ_LAT; i++) begin
                    pipe_p[p][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_req[p]) begin
                    pipe_p[p][0] <= par_samp[p];
                end
                for (int i = 1; i < READ_LAT; i++) begin
                    if (pipe_v[p][i-1]) begin
                        pipe_p[p][i] <= pipe_p[p][i-1];
                    end
                end
            end
        end
    end

    assign perr_o = (qv_a_o && (lane_par(q_a_o) != pipe_p[0][READ_LAT-1]))
                 || (qv_b_o && (lane_par(q_b_o) != pipe_p[1][READ_LAT-1]));
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj_i;
    assign perr_o          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_emulator_dp.sv
// tb/tb_mem_emulator_dp.sv - self-checking bench for mem_emulator_dp: table vectors, directed corners, random vs model
module tb_mem_emulator_dp;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int SIZE   = 200;
    localparam int LAT    = 3;
    localparam int AW     = $clog2(SIZE);
    localparam int DW     = LANES * LANE_W;
`ifdef MEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int OP_IDLE = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;

    logic             clk = 1'b0;
    logic             rst, busy, cenb_a, wenb_a, qv_a, cenb_b, qv_b, addr_err, perr_inj, perr;
    logic [AW-1:0]    addr_a, addr_b;
    logic [LANES-1:0] wmask_a;
    logic [DW-1:0]    d_a, q_a, q_b;

    mem_emulator_dp #(.LANES(LANES), .LANE_W(LANE_W), .SIZE(SIZE), .READ_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .busy_o(busy),
        .cenb_a_i(cenb_a), .wenb_a_i(wenb_a), .addr_a_i(addr_a), .wmask_a_i(wmask_a),
        .d_a_i(d_a), .q_a_o(q_a), .qv_a_o(qv_a),
        .cenb_b_i(cenb_b), .addr_b_i(addr_b), .q_b_o(q_b), .qv_b_o(qv_b),
        .addr_err_o(addr_err), .perr_inj_i(perr_inj), .perr_o(perr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference: word array, per-lane "stored bad parity" flags, and a queue of due returns.
    logic [DW-1:0]    mdl_mem [SIZE];
    logic [LANES-1:0] mdl_bad [SIZE];
    int               init_left = 0;
    bit               mdl_err = 1'b0;
    logic [DW-1:0]    e_qa = '0, e_qb = '0;
    bit               e_qva, e_qvb, e_perr;
    typedef struct { int due; int port; logic [DW-1:0] data; bit bad; } ret_t;
    ret_t pend[$];

    typedef struct {
        int a_op; int a_addr; logic [DW-1:0] a_d; logic [LANES-1:0] a_mask;
        bit b_rd; int b_addr; logic [DW-1:0] exp_a; logic [DW-1:0] exp_b;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic model_edge();
        ret_t r;
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                mdl_mem[i] = '0;
                mdl_bad[i] = '0;
            end
            init_left = SIZE;
            mdl_err   = 1'b0;
            pend.delete();
            e_qa = '0;
            e_qb = '0;
            return;
        end
        if (init_left > 0) begin
            init_left--;
            return;
        end
        if (!cenb_b) begin
            r.due = cyc + LAT; r.port = 1; r.data = '0; r.bad = 1'b0;
            if (int'(addr_b) < SIZE) begin
                r.data = mdl_mem[addr_b];
                r.bad  = |mdl_bad[addr_b];
            end else begin
                mdl_err = 1'b1;
            end
            pend.push_back(r);
        end
        if (!cenb_a) begin
            r.due = cyc + LAT; r.port = 0; r.data = '0; r.bad = 1'b0;
            if (int'(addr_a) >= SIZE) begin
                mdl_err = 1'b1;
                if (wenb_a) pend.push_back(r);
            end else if (wenb_a) begin
                r.data = mdl_mem[addr_a];
                r.bad  = |mdl_bad[addr_a];
                pend.push_back(r);
            end else begin
                for (int k = 0; k < LANES; k++) begin
                    if (wmask_a[k]) begin
                        mdl_mem[addr_a][k*LANE_W +: LANE_W] = d_a[k*LANE_W +: LANE_W];
                        mdl_bad[addr_a][k] = PAR & perr_inj;
                    end
                end
            end
        end
    endtask

    task automatic model_post();
        ret_t r;
        e_qva = 1'b0; e_qvb = 1'b0; e_perr = 1'b0;
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            if (r.port == 0) begin e_qva = 1'b1; e_qa = r.data; end
            else             begin e_qvb = 1'b1; e_qb = r.data; end
            e_perr = e_perr | r.bad;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        model_post();
        check("busy", busy, init_left > 0);
        check("qv_a", qv_a, e_qva);
        check("qv_b", qv_b, e_qvb);
        check("q_a", q_a, e_qa);
        check("q_b", q_b, e_qb);
        check("addr_err", addr_err, mdl_err);
        check("perr", perr, e_perr);
    endtask

    task automatic idle();
        cenb_a = 1'b1; wenb_a = 1'b1; addr_a = '0; wmask_a = '0; d_a = '0; perr_inj = 1'b0;
        cenb_b = 1'b1; addr_b = '0;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data, input logic [LANES-1:0] mask, input logic inj);
        idle();
        cenb_a = 1'b0; wenb_a = 1'b0; addr_a = AW'(addr); d_a = data; wmask_a = mask; perr_inj = inj;
        tick();
        idle();
    endtask

    task automatic rd_chk(input string name, input int port, input int addr, input logic [DW-1:0] exp);
        idle();
        if (port == 0) begin cenb_a = 1'b0; wenb_a = 1'b1; addr_a = AW'(addr); end
        else           begin cenb_b = 1'b0; addr_b = AW'(addr); end
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        check({name, "_qv"}, (port == 0) ? qv_a : qv_b, 1);
        check({name, "_q"}, (port == 0) ? q_a : q_b, exp);
    endtask

    // Pulses reset once, then counts busy cycles while hammering both ports with requests that must be ignored.
    task automatic reset_and_init(input string name);
        int n, pulses;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({name, "_rst_busy"}, busy, 1);
        check({name, "_rst_qa"}, q_a, 0);
        check({name, "_rst_qv"}, qv_a | qv_b, 0);
        check({name, "_rst_err"}, addr_err, 0);
        n = 0;
        pulses = 0;
        while (busy === 1'b1 && n < SIZE + 20) begin
            cenb_a = 1'b0; wenb_a = 1'b0; addr_a = AW'(7); d_a = '1; wmask_a = '1;
            cenb_b = 1'b0; addr_b = AW'(n % SIZE);
            tick();
            n++;
            if (qv_a || qv_b) pulses++;
        end
        idle();
        check({name, "_busy_cycles"}, n, SIZE);
        check({name, "_busy_pulses"}, pulses, 0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return AW'($urandom_range(0, 7));
        if (r < 19) return AW'($urandom_range(0, SIZE - 1));
        return AW'($urandom_range(SIZE, (1 << AW) - 1));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{OP_WR,   5, 32'h44332211, 4'b1111, 1'b0,   0, 32'h0,        32'h0};
        vecs[1] = '{OP_RD,   5, 32'h0,        4'b0000, 1'b0,   0, 32'h44332211, 32'h0};
        vecs[2] = '{OP_WR,   5, 32'hAABBCCDD, 4'b0101, 1'b0,   0, 32'h0,        32'h0};
        vecs[3] = '{OP_RD,   5, 32'h0,        4'b0000, 1'b1,   5, 32'h44BB22DD, 32'h44BB22DD};
        vecs[4] = '{OP_IDLE, 0, 32'h0,        4'b0000, 1'b1,   0, 32'h0,        32'h0};
        vecs[5] = '{OP_WR,   9, 32'h00000001, 4'b1111, 1'b1,   9, 32'h0,        32'h0};
        vecs[6] = '{OP_IDLE, 0, 32'h0,        4'b0000, 1'b1,   9, 32'h0,        32'h00000001};
        vecs[7] = '{OP_RD, 199, 32'h0,        4'b0000, 1'b0,   0, 32'h0,        32'h0};
        vecs[8] = '{OP_WR, 199, 32'hDEADBEEF, 4'b1000, 1'b0,   0, 32'h0,        32'h0};
        vecs[9] = '{OP_RD, 199, 32'h0,        4'b0000, 1'b1, 199, 32'hDE000000, 32'hDE000000};

        idle();
        rst = 1'b1;
        reset_and_init("por");
        rd_chk("por_z0", 0, 0, 0);
        rd_chk("por_z100", 1, 100, 0);
        rd_chk("por_z199", 0, SIZE - 1, 0);
        rd_chk("busy_ign7", 1, 7, 0);

        for (int v = 0; v < 10; v++) begin
            idle();
            if (vecs[v].a_op != OP_IDLE) begin
                cenb_a = 1'b0; wenb_a = (vecs[v].a_op == OP_RD);
                addr_a = AW'(vecs[v].a_addr); d_a = vecs[v].a_d; wmask_a = vecs[v].a_mask;
            end
            if (vecs[v].b_rd) begin
                cenb_b = 1'b0; addr_b = AW'(vecs[v].b_addr);
            end
            tick();
            idle();
            for (int i = 1; i < LAT; i++) tick();
            if (vecs[v].a_op == OP_RD) begin
                check($sformatf("vec%0d_qv_a", v), qv_a, 1);
                check($sformatf("vec%0d_q_a", v), q_a, vecs[v].exp_a);
            end
            if (vecs[v].b_rd) begin
                check($sformatf("vec%0d_qv_b", v), qv_b, 1);
                check($sformatf("vec%0d_q_b", v), q_b, vecs[v].exp_b);
            end
        end

        // Collision then immediate re-read on both ports.
        idle();
        cenb_a = 1'b0; wenb_a = 1'b0; addr_a = AW'(11); d_a = 32'h00000077; wmask_a = '1;
        cenb_b = 1'b0; addr_b = AW'(11);
        tick();
        idle();
        cenb_a = 1'b0; wenb_a = 1'b1; addr_a = AW'(11);
        cenb_b = 1'b0; addr_b = AW'(11);
        tick();
        idle();
        for (int i = 0; i < LAT - 2; i++) tick();
        check("coll_old_qv_b", qv_b, 1);
        check("coll_old_q_b", q_b, 0);
        tick();
        check("coll_new_q_a", q_a, 32'h77);
        check("coll_new_q_b", q_b, 32'h77);

        for (int n = 0; n < 800; n++) begin
            cenb_a   = ($urandom_range(0, 3) == 0);
            wenb_a   = 1'($urandom_range(0, 1));
            addr_a   = rnd_addr();
            d_a      = $urandom();
            wmask_a  = LANES'($urandom_range(0, 15));
            perr_inj = ($urandom_range(0, 7) == 0);
            cenb_b   = ($urandom_range(0, 2) == 0);
            addr_b   = rnd_addr();
            tick();
        end
        idle();
        for (int i = 0; i < LAT; i++) tick();

        // Reset while three reads are in flight.
        wr(20, 32'h12345678, '1, 1'b0);
        wr(21, 32'h9ABCDEF0, '1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            cenb_a = 1'b0; wenb_a = 1'b1; addr_a = AW'(20);
            cenb_b = 1'b0; addr_b = AW'(21);
            tick();
        end
        reset_and_init("midrd");
        rd_chk("midrd_z20", 0, 20, 0);
        rd_chk("midrd_z21", 1, 21, 0);

        check("err_clear", addr_err, 0);
        wr(10, 32'hCAFEF00D, '1, 1'b0);
        wr(210, 32'hFFFFFFFF, '1, 1'b0);
        check("err_set", addr_err, 1);
        rd_chk("oor_keep10", 0, 10, 32'hCAFEF00D);
        rd_chk("oor_keep82", 1, 82, 0);
        rd_chk("oor_rd210", 1, 210, 0);
        check("err_sticky", addr_err, 1);

        wr(3, 32'h01020304, '1, 1'b1);
        idle();
        cenb_a = 1'b0; wenb_a = 1'b1; addr_a = AW'(3);
        cenb_b = 1'b0; addr_b = AW'(3);
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        check("par_inj_qv", qv_a & qv_b, 1);
        check("par_inj_perr", perr, PAR);
        wr(3, 32'h01020304, '1, 1'b0);
        rd_chk("par_clean", 0, 3, 32'h01020304);
        check("par_clean_perr", perr, 0);
        wr(4, 32'h00005500, 4'b0010, 1'b1);
        rd_chk("par_lane1", 1, 4, 32'h00005500);
        check("par_lane1_perr", perr, PAR);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_emulator_dp.md
Name: mem_emulator_dp

Overview:
Parametrised successor to the single-port behavioural buffer memory used around matrix_mult_wrapper. It adds per-lane write masking, a configurable read-latency pipeline with a valid strobe, and a second read-only port so the output/psum buffers can be read and written in the same cycle. It also adds a self-zeroing init sequence after reset. It sits beside the systolic array as the OB/PS/IB/WB buffer model and is synthesizable so it can stand in for SRAM macros in FPGA builds.

Parameters:
LANES, 4, number of data lanes per word (matches COL or ROW)
LANE_W, 8, bits per lane (matches WIDTH)
SIZE, 256, number of words; need not be a power of two
READ_LAT, 1, read latency in cycles, legal range 1..4; out of range is an elaboration error
ADDR_W, $clog2(SIZE), address width (derived; do not override)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset; synchronous to clk_i, active-high
busy_o  out  1  high while the init sequence runs
cenb_a_i  in  1  port A chip enable, active-low
wenb_a_i  in  1  port A write enable, active-low (0 = write, 1 = read)
addr_a_i  in  ADDR_W  port A address
wmask_a_i  in  LANES  port A per-lane write mask, 1 = write lane
d_a_i  in  LANES*LANE_W  port A write data, lane k = bits [k*LANE_W +: LANE_W]
q_a_o  out  LANES*LANE_W  port A read data
qv_a_o  out  1  port A read-data valid pulse
cenb_b_i  in  1  port B (read-only) chip enable, active-low
addr_b_i  in  ADDR_W  port B address
q_b_o  out  LANES*LANE_W  port B read data
qv_b_o  out  1  port B read-data valid pulse
addr_err_o  out  1  sticky flag: an access used addr >= SIZE
perr_inj_i  in  1  parity-error inject on port A write; ignored without MEM_PARITY_EN
perr_o  out  1  parity mismatch on returned data, aligned with qv_a_o/qv_b_o

Behaviour:
- Reset values: busy_o=1, q_a_o=q_b_o=0, qv_a_o=qv_b_o=0, addr_err_o=0, perr_o=0. All read pipelines are flushed.
- FSM states: INIT, READY.
  - rst_i forces INIT with init counter 0.
  - In INIT, one word per cycle (word = counter value) is written to all-zero with correct parity, and the counter increments.
  - When the counter reaches SIZE-1, that word is written and the FSM moves to READY. busy_o deasserts on the first READY cycle, so busy_o is high for exactly SIZE cycles after rst_i falls.
- Port requests while busy_o=1 are ignored: no write, no valid pulse, addr_err_o not updated.
- Port A write (cenb=0, wenb=0): lane k is updated iff wmask_a_i[k]=1. Unmasked lanes keep their contents. No valid pulse.
- Port A or B read (cenb=0, wenb=1 for A; cenb=0 for B):
  - The array is sampled at the request edge.
  - The data and a valid pulse are presented exactly READ_LAT cycles later.
  - Back-to-back reads are fully pipelined, one result per cycle.
  - q_x_o holds its last valid value between pulses.
- Same-cycle collision (A write and B read to the same address): B returns the pre-write contents (read-first). Any read issued on the next cycle returns the new data.
- Both ports reading the same address in the same cycle is legal; both return identical data.
- Address >= SIZE:
  - writes are dropped;
  - reads still pulse valid, with data 0;
  - addr_err_o sets and stays set until rst_i.
- cenb=1 means no effect, with X tolerated on the other inputs of that port.
- rst_i asserted mid-operation: in-flight reads are discarded (no late valid pulses), and the array is re-zeroed by INIT.

Optional Feature:
MEM_PARITY_EN:
- Defined:
  - One even-parity bit is stored per lane.
  - A port A write with perr_inj_i=1 stores inverted parity for the written lanes.
  - On every read return, perr_o=1 in the same cycle as the valid pulse if any lane mismatches. Each port is checked independently and the results are ORed.
- Not defined: no parity storage, perr_o tied 0, perr_inj_i unused.

Test Plan:
- Reset with SIZE=256: pulse rst_i one cycle, then read addr 0, 128, 255 after busy_o falls -> busy_o high exactly 256 cycles; all reads return 0 with qv pulses.
- READ_LAT=2: write addr 5 = 0x44332211, mask 4'b1111; read A addr 5 next cycle -> qv_a_o exactly 2 cycles after the request, q_a_o=0x44332211.
- Masked write: write addr 5 = 0xAABBCCDD, mask 4'b0101; read -> 0x44BB22DD.
- Collision: A writes addr 9 = 0x1 while B reads addr 9 -> q_b_o=0x0; B reads addr 9 the following cycle -> 0x1.
- Reset mid-read: issue reads on 3 consecutive cycles with READ_LAT=3, assert rst_i the cycle after the last read -> no qv pulses; busy_o=1; previously written words read 0 after INIT. Also with SIZE=200, write addr 210 -> addr_err_o=1 and no word is modified.
- MEM_PARITY_EN: write addr 3 with perr_inj_i=1, then read A and B addr 3 -> perr_o=1 with each valid pulse; a clean rewrite, then read -> perr_o=0. Without the macro, perr_o stays 0.
